// File: rtl/ring_rand_arb.sv
`default_nettype none
// ============================================================================
// Module      : ring_rand_arb
// Description : Round-robin arbiter and sequencer for the random-access read
//               port of the 128-entry ring buffer in the frequency selector
//               datapath. One random read is in flight at a time; the sample
//               is captured and routed back to the winning requester. The
//               streaming read path is gated off while a random read is busy.
//
// Ports
//   clk            single clock
//   rst            synchronous reset, active-high
//   req            per-requester read request (level, held until response)
//   req_addr       packed per-requester addresses, slice i = [i*ADDR_W +: ADDR_W]
//   rsp_data       captured sample, qualified by a rsp_valid bit
//   rsp_valid      one-hot single-cycle completion pulse
//   rsp_err        one-hot single-cycle timeout-abort pulse
//   rand_rd_addr   ring random-read address
//   rand_rd_en     ring random-read enable
//   rand_rd_valid  ring random sample strobe
//   ring_dout      ring data output
//   ring_ready     ring streaming ready
//   stream_rd_en   downstream streaming read request
//   stream_ready   streaming ready, gated to IDLE
//   ring_rd_en     ring streaming read enable, gated to IDLE
//
// Revision    : 1.0  initial release
// ============================================================================
module ring_rand_arb #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 14,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [N_REQ-1:0]          rsp_err,
    output logic [ADDR_W-1:0]         rand_rd_addr,
    output logic                      rand_rd_en,
    input  logic                      rand_rd_valid,
    input  logic [DATA_W-1:0]         ring_dout,
    input  logic                      ring_ready,
    input  logic                      stream_rd_en,
    output logic                      stream_ready,
    output logic                      ring_rd_en
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_POS_W = c_IDX_W + 1;
    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_REQ - 1);
    localparam logic [c_POS_W-1:0] c_POS_N    = c_POS_W'(N_REQ);
    localparam logic [N_REQ-1:0]   c_ONE      = N_REQ'(1);

    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  r_gnt_idx;
    logic [c_CNT_W-1:0]  r_to_cnt;
    logic [ADDR_W-1:0]   r_rand_rd_addr;
    logic                r_rand_rd_en;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [N_REQ-1:0]    r_rsp_valid;
    logic [N_REQ-1:0]    r_rsp_err;

    logic                w_idle;
    logic                w_found;
    logic [c_IDX_W-1:0]  w_gnt;
    logic [c_POS_W-1:0]  w_pos;
    logic [ADDR_W-1:0]   w_addr;

    assign w_idle = (r_state == c_ST_IDLE);

    // Rotating priority search: first asserted request at or after r_rr_ptr,
    // wrapping modulo N_REQ. One extra bit on w_pos keeps the wrap compare
    // exact for non-power-of-two N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pos = {1'b0, r_rr_ptr} + c_POS_W'(i);
            if (w_pos >= c_POS_N) begin
                w_pos = w_pos - c_POS_N;
            end
            if (!w_found && req[w_pos[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_pos[c_IDX_W-1:0];
            end
        end
    end

    // Address slice of the winning requester
    always_comb begin
        w_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == c_IDX_W'(i)) begin
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_rr_ptr       <= '0;
            r_gnt_idx      <= '0;
            r_to_cnt       <= '0;
            r_rand_rd_addr <= '0;
            r_rand_rd_en   <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_valid    <= '0;
            r_rsp_err      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_gnt_idx      <= w_gnt;
                        r_rand_rd_addr <= w_addr;
                        r_rand_rd_en   <= 1'b1;
                        r_to_cnt       <= '0;
                        r_state        <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (r_to_cnt != c_TO_LAST) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    // A sample arriving on the last timeout cycle still counts
                    if (rand_rd_valid) begin
                        r_rsp_data   <= ring_dout;
                        r_rsp_valid  <= c_ONE << r_gnt_idx;
                        r_rand_rd_en <= 1'b0;
                        r_state      <= c_ST_RESP;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_rsp_err    <= c_ONE << r_gnt_idx;
                        r_rand_rd_en <= 1'b0;
                        r_state      <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    // Enable is already low here, so the ring's random
                    // counter finishing this cycle cannot re-trigger a read.
                    r_rsp_valid <= '0;
                    r_rsp_err   <= '0;
                    r_rr_ptr    <= (r_gnt_idx == c_IDX_LAST) ? '0 : r_gnt_idx + 1'b1;
                    r_state     <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_data     = r_rsp_data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rand_rd_addr = r_rand_rd_addr;
    assign rand_rd_en   = r_rand_rd_en;
    assign stream_ready = ring_ready & w_idle;
    assign ring_rd_en   = stream_rd_en & w_idle;

endmodule
`default_nettype wire

// File: tb/tb_ring_rand_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_rand_arb
// Description : Self-checking bench for ring_rand_arb. Stimulus pushes the
//               expected responses into a scoreboard queue; a monitor pops
//               and compares whenever a rsp_valid/rsp_err pulse appears.
//               A small ring model returns samples after a set latency.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ring_rand_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [13:0] rsp_data;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_err;
    logic [6:0]  rand_rd_addr;
    logic        rand_rd_en;
    logic        rand_rd_valid;
    logic [13:0] ring_dout;
    logic        ring_ready;
    logic        stream_rd_en;
    logic        stream_ready;
    logic        ring_rd_en;

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  err;
        logic [13:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    int          cyc;
    int          ring_lat;
    int          ring_cnt;
    logic        prev_en;
    logic [13:0] mem [128];
    logic [13:0] dat [4];

    ring_rand_arb #(
        .N_REQ   (4),
        .ADDR_W  (7),
        .DATA_W  (14),
        .TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_addr      (req_addr),
        .rsp_data      (rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rand_rd_addr  (rand_rd_addr),
        .rand_rd_en    (rand_rd_en),
        .rand_rd_valid (rand_rd_valid),
        .ring_dout     (ring_dout),
        .ring_ready    (ring_ready),
        .stream_rd_en  (stream_rd_en),
        .stream_ready  (stream_ready),
        .ring_rd_en    (ring_rd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input logic [3:0] v, input logic [3:0] e, input logic [13:0] d, input int c);
        exp_t x;
        x.vld  = v;
        x.err  = e;
        x.data = d;
        x.cyc  = c;
        sb.push_back(x);
    endtask

    // Ring model: a rising rand_rd_en starts a countdown of ring_lat cycles,
    // after which rand_rd_valid pulses with the addressed sample.
    initial begin
        rand_rd_valid = 1'b0;
        ring_dout     = 14'h0555;
        ring_cnt      = 0;
        prev_en       = 1'b0;
        forever begin
            tick();
            rand_rd_valid = 1'b0;
            ring_dout     = 14'h0555;
            if (ring_cnt > 0) begin
                ring_cnt--;
                if (ring_cnt == 0) begin
                    rand_rd_valid = 1'b1;
                    ring_dout     = mem[rand_rd_addr];
                end
            end else if (rand_rd_en && !prev_en && ring_lat > 0) begin
                ring_cnt = ring_lat;
            end
            prev_en = rand_rd_en;
        end
    end

    // Monitor: every response pulse must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid !== 4'd0 || rsp_err !== 4'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", {24'd0, rsp_valid, rsp_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, e.vld});
                    chk("rsp_err",   {28'd0, rsp_err},   {28'd0, e.err});
                    chk("rsp_data",  {18'd0, rsp_data},  {18'd0, e.data});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 128; i++) mem[i] = 14'h0AAA ^ 14'(i);
        mem[5]   = 14'h0123;
        mem[37]  = 14'h1ABC;
        mem[64]  = 14'h2DEF;
        mem[100] = 14'h3456;
        dat[0] = 14'h0123;
        dat[1] = 14'h1ABC;
        dat[2] = 14'h2DEF;
        dat[3] = 14'h3456;

        rst          = 1'b1;
        req          = 4'd0;
        req_addr     = {7'd100, 7'd64, 7'd37, 7'd5};
        stream_rd_en = 1'b1;
        ring_ready   = 1'b1;
        ring_lat     = 2;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_rand_rd_en",   {31'd0, rand_rd_en}, 32'd0);
        chk("rst_rand_rd_addr", {25'd0, rand_rd_addr}, 32'd0);
        chk("rst_rsp_data",     {18'd0, rsp_data}, 32'd0);
        chk("rst_rsp_valid",    {28'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",      {28'd0, rsp_err}, 32'd0);
        chk("rst_ring_rd_en",   {31'd0, ring_rd_en}, 32'd1);
        chk("rst_stream_ready", {31'd0, stream_ready}, 32'd1);
        tick();
        ring_ready   = 1'b0;
        stream_rd_en = 1'b0;
        @(negedge clk);
        chk("gate_stream_ready_lo", {31'd0, stream_ready}, 32'd0);
        chk("gate_ring_rd_en_lo",   {31'd0, ring_rd_en}, 32'd0);
        tick();
        ring_ready   = 1'b1;
        stream_rd_en = 1'b1;
        rst          = 1'b0;

        // Single request from requester 1, with stream gating checked
        tick();
        t0  = cyc;
        req = 4'b0010;
        push(4'b0010, 4'b0000, 14'h1ABC, t0 + 4);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (k == 4) req = 4'd0;
            @(negedge clk);
            chk("single_ring_rd_en",   {31'd0, ring_rd_en},   (k == 0 || k == 5) ? 32'd1 : 32'd0);
            chk("single_stream_ready", {31'd0, stream_ready}, (k == 0 || k == 5) ? 32'd1 : 32'd0);
            chk("single_rand_rd_en",   {31'd0, rand_rd_en},   (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
            if (k == 1) chk("single_rand_rd_addr", {25'd0, rand_rd_addr}, 32'd37);
        end

        // rr_ptr is now 2: requesters 0 and 2 -> 2 wins, then 0
        tick();
        t0  = cyc;
        req = 4'b0101;
        push(4'b0100, 4'b0000, 14'h2DEF, t0 + 4);
        push(4'b0001, 4'b0000, 14'h0123, t0 + 9);
        wait_to(t0 + 4);
        req = 4'b0001;
        wait_to(t0 + 9);
        req = 4'd0;

        // Reset in cycle 2 of a transaction (requester 1 granted)
        tick();
        t0  = cyc;
        req = 4'b0010;
        wait_to(t0 + 1);
        @(negedge clk);
        chk("rstmid_rand_rd_en_pre", {31'd0, rand_rd_en}, 32'd1);
        wait_to(t0 + 2);
        rst = 1'b1;
        req = 4'd0;
        wait_to(t0 + 3);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_rand_rd_en", {31'd0, rand_rd_en}, 32'd0);
        chk("rstmid_rsp_valid",  {28'd0, rsp_valid}, 32'd0);
        chk("rstmid_rsp_err",    {28'd0, rsp_err}, 32'd0);
        chk("rstmid_ring_rd_en", {31'd0, ring_rd_en}, 32'd1);
        chk("rstmid_rsp_data",   {18'd0, rsp_data}, 32'd0);
        wait_to(t0 + 6);

        // Round robin, all held, rr_ptr back at 0 after reset
        tick();
        t0  = cyc;
        req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            push(4'b0001 << (k % 4), 4'b0000, dat[k % 4], t0 + 4 + 5 * k);
        end
        wait_to(t0 + 59);
        req = 4'd0;
        wait_to(t0 + 62);

        // Timeout on requester 0, then requester 1 served; rsp_data holds
        tick();
        t0       = cyc;
        ring_lat = 0;
        req      = 4'b0011;
        push(4'b0000, 4'b0001, 14'h3456, t0 + 65);
        push(4'b0010, 4'b0000, 14'h1ABC, t0 + 70);
        wait_to(t0 + 2);
        ring_lat = 2;
        wait_to(t0 + 64);
        @(negedge clk);
        chk("to_rand_rd_en_hold", {31'd0, rand_rd_en}, 32'd1);
        wait_to(t0 + 65);
        req = 4'b0010;
        @(negedge clk);
        chk("to_rand_rd_en_drop", {31'd0, rand_rd_en}, 32'd0);
        wait_to(t0 + 70);
        req = 4'd0;
        wait_to(t0 + 72);

        // Sample arrives when to_cnt reaches 63: valid beats timeout
        tick();
        t0       = cyc;
        ring_lat = 63;
        req      = 4'b0100;
        push(4'b0100, 4'b0000, 14'h2DEF, t0 + 65);
        wait_to(t0 + 2);
        ring_lat = 2;
        wait_to(t0 + 65);
        req = 4'd0;
        wait_to(t0 + 70);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
